// File: rtl/bus_slave_ctrl_pkg.sv
// rtl/bus_slave_ctrl_pkg.sv - shared bus constants and slave controller types
// Purpose: bus-wide constants (active-low enables, read/write encoding,
//          word address/data widths) plus the slave controller state
//          encodings and wait/timeout counter width.
// Ports:   none (package).
package bus_slave_ctrl_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  localparam int BUS_SLV_STATE_W = 2;
  localparam int BUS_SLV_CNT_W   = 8;

  typedef enum logic [BUS_SLV_STATE_W-1:0] {
    BUS_SLV_STATE_IDLE = 2'd0,
    BUS_SLV_STATE_WAIT = 2'd1,
    BUS_SLV_STATE_DEV  = 2'd2,
    BUS_SLV_STATE_RDY  = 2'd3
  } bus_slv_state_t;

endpackage

// File: rtl/bus_slave_ctrl_timer.sv
// rtl/bus_slave_ctrl_timer.sv - 8-bit loadable down-counter with zero flag
// Purpose: module bus_slave_timer; counts wait states and device timeout.
// Ports:   clk, reset (async, active-high), load + load_value (load has
//          priority), dec (decrement, saturates at 0), zero (count == 0).
module bus_slave_timer
  import bus_slave_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [BUS_SLV_CNT_W-1:0] load_value,
  input  logic                     dec,
  output logic                     zero
);

  logic [BUS_SLV_CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_slave_ctrl.sv
// rtl/bus_slave_ctrl.sv - bus slave responder with wait states and device handshake
// Purpose: accepts a selected strobe, inserts WAIT_CYCLES idle cycles,
//          drives a level request to the device until dev_ack, then returns
//          a one-cycle active-low rdy_ with read data.
// Optional: BUS_SLAVE_CTRL_TIMEOUT_EN adds a device-acknowledge timeout
//          (TIMEOUT_CYCLES) and the bus_err output.
// Ports:   clk, reset (async, active-high);
//          bus side: cs_, as_, rw, addr, wr_data in; rd_data, rdy_ out;
//          device side: dev_req, dev_addr, dev_rw, dev_wr_data out;
//          dev_rd_data, dev_ack in; bus_err out (optional).
module bus_slave_ctrl
  import bus_slave_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES    = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic [WORD_DATA_W-1:0] rd_data,
  output logic                   rdy_,
  output logic                   dev_req,
  output logic [WORD_ADDR_W-1:0] dev_addr,
  output logic                   dev_rw,
  output logic [WORD_DATA_W-1:0] dev_wr_data,
  input  logic [WORD_DATA_W-1:0] dev_rd_data,
`ifdef BUS_SLAVE_CTRL_TIMEOUT_EN
  output logic                   bus_err,
`endif
  input  logic                   dev_ack
);

  // Count of WAIT_CYCLES-1 because the IDLE->WAIT edge is itself one wait cycle.
  localparam logic [BUS_SLV_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : BUS_SLV_CNT_W'(WAIT_CYCLES - 1);

  bus_slv_state_t state;
  logic           strobe;
  logic           wait_zero;

  assign strobe = (cs_ == ENABLE_) && (as_ == ENABLE_);

  bus_slave_timer u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .load       ((state == BUS_SLV_STATE_IDLE) && strobe),
    .load_value (WAIT_LOAD),
    .dec        (state == BUS_SLV_STATE_WAIT),
    .zero       (wait_zero)
  );

`ifdef BUS_SLAVE_CTRL_TIMEOUT_EN
  // Loaded with TIMEOUT_CYCLES-1 on DEV entry so dev_req is up for
  // exactly TIMEOUT_CYCLES cycles before expiry.
  localparam logic [BUS_SLV_CNT_W-1:0] TO_LOAD = BUS_SLV_CNT_W'(TIMEOUT_CYCLES - 1);
  logic dev_enter;
  logic to_zero;

  assign dev_enter = ((state == BUS_SLV_STATE_IDLE) && strobe && (WAIT_CYCLES == 0)) ||
                     ((state == BUS_SLV_STATE_WAIT) && wait_zero);

  bus_slave_timer u_timeout_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (dev_enter),
    .load_value (TO_LOAD),
    .dec        (state == BUS_SLV_STATE_DEV),
    .zero       (to_zero)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BUS_SLV_STATE_IDLE;
      rdy_        <= DISABLE_;
      rd_data     <= '0;
      dev_req     <= 1'b0;
      dev_addr    <= '0;
      dev_rw      <= READ;
      dev_wr_data <= '0;
`ifdef BUS_SLAVE_CTRL_TIMEOUT_EN
      bus_err     <= 1'b0;
`endif
    end else begin
      case (state)
        BUS_SLV_STATE_IDLE: begin
          if (strobe) begin
            dev_addr    <= addr;
            dev_rw      <= rw;
            dev_wr_data <= wr_data;
            if (WAIT_CYCLES == 0) begin
              dev_req <= 1'b1;
              state   <= BUS_SLV_STATE_DEV;
            end else begin
              state   <= BUS_SLV_STATE_WAIT;
            end
          end
        end
        BUS_SLV_STATE_WAIT: begin
          if (wait_zero) begin
            dev_req <= 1'b1;
            state   <= BUS_SLV_STATE_DEV;
          end
        end
        BUS_SLV_STATE_DEV: begin
          // Acknowledge is checked first so it wins over a coincident expiry.
          if (dev_ack) begin
            dev_req <= 1'b0;
            rdy_    <= ENABLE_;
            rd_data <= (dev_rw == WRITE) ? '0 : dev_rd_data;
            state   <= BUS_SLV_STATE_RDY;
          end
`ifdef BUS_SLAVE_CTRL_TIMEOUT_EN
          else if (to_zero) begin
            dev_req <= 1'b0;
            rdy_    <= ENABLE_;
            rd_data <= '0;
            bus_err <= 1'b1;
            state   <= BUS_SLV_STATE_RDY;
          end
`endif
        end
        BUS_SLV_STATE_RDY: begin
          rdy_        <= DISABLE_;
          rd_data     <= '0;
          dev_addr    <= '0;
          dev_rw      <= READ;
          dev_wr_data <= '0;
`ifdef BUS_SLAVE_CTRL_TIMEOUT_EN
          bus_err     <= 1'b0;
`endif
          state       <= BUS_SLV_STATE_IDLE;
        end
        default: state <= BUS_SLV_STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slave_ctrl.sv
// tb/tb_bus_slave_ctrl.sv - directed scoreboard bench for bus_slave_ctrl
// Instance 0 uses WAIT_CYCLES=0, instance 1 uses WAIT_CYCLES=3.
// With BUS_SLAVE_CTRL_TIMEOUT_EN both use TIMEOUT_CYCLES=4.
module tb_bus_slave_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
    logic        err;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cs_n = 2'b11;
  logic        as_n = 1'b1;
  logic        rw = 1'b1;
  logic [29:0] addr = '0;
  logic [31:0] wr_data = '0;

  logic [31:0] rd_v [2];
  logic [1:0]  rdy_v;
  logic [1:0]  dev_req_v;
  logic [29:0] dev_addr_v [2];
  logic [1:0]  dev_rw_v;
  logic [31:0] dev_wr_v [2];
  logic [31:0] dev_rd [2];
  logic [1:0]  auto_ack = 2'b00;
  logic [1:0]  man_ack = 2'b00;
  logic [1:0]  mute = 2'b00;
  logic [1:0]  err_v;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pulses [2];
  int   age [2];
  int   ack_delay [2];
  bit   mon_en = 1'b0;
  sb_t  sb_q [2][$];
  logic [31:0] dq [2][$];
  sb_t  mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_slave_ctrl #(
    .WAIT_CYCLES(0)
`ifdef BUS_SLAVE_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) u_dut0 (
    .clk(clk), .reset(reset), .cs_(cs_n[0]), .as_(as_n), .rw(rw),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_v[0]), .rdy_(rdy_v[0]),
    .dev_req(dev_req_v[0]), .dev_addr(dev_addr_v[0]), .dev_rw(dev_rw_v[0]),
    .dev_wr_data(dev_wr_v[0]), .dev_rd_data(dev_rd[0]),
`ifdef BUS_SLAVE_CTRL_TIMEOUT_EN
    .bus_err(err_v[0]),
`endif
    .dev_ack(auto_ack[0] | man_ack[0])
  );

  bus_slave_ctrl #(
    .WAIT_CYCLES(3)
`ifdef BUS_SLAVE_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) u_dut3 (
    .clk(clk), .reset(reset), .cs_(cs_n[1]), .as_(as_n), .rw(rw),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_v[1]), .rdy_(rdy_v[1]),
    .dev_req(dev_req_v[1]), .dev_addr(dev_addr_v[1]), .dev_rw(dev_rw_v[1]),
    .dev_wr_data(dev_wr_v[1]), .dev_rd_data(dev_rd[1]),
`ifdef BUS_SLAVE_CTRL_TIMEOUT_EN
    .bus_err(err_v[1]),
`endif
    .dev_ack(auto_ack[1] | man_ack[1])
  );

`ifndef BUS_SLAVE_CTRL_TIMEOUT_EN
  assign err_v = 2'b00;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Device model: acks ack_delay cycles after it first sees dev_req.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      auto_ack[i] = 1'b0;
      if (dev_req_v[i] === 1'b1 && !mute[i]) begin
        if (age[i] == ack_delay[i]) begin
          auto_ack[i] = 1'b1;
          dev_rd[i] = (dq[i].size() > 0) ? dq[i].pop_front() : 32'h0;
        end
        age[i]++;
      end else begin
        age[i] = 0;
      end
    end
  end

  // Scoreboard: every rdy_ pulse must match the next expected access.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (rdy_v[i] === 1'b0) begin
          pulses[i]++;
          if (sb_q[i].size() == 0) begin
            check("rdy_unexpected", {31'b0, rdy_v[i]}, 32'h1);
          end else begin
            mon_e = sb_q[i].pop_front();
            check("rd_data", rd_v[i], mon_e.data);
            check("rdy_cycle", cyc, mon_e.due);
`ifdef BUS_SLAVE_CTRL_TIMEOUT_EN
            check("bus_err", {31'b0, err_v[i]}, {31'b0, mon_e.err});
`endif
          end
        end else begin
          check("rd_data_idle", rd_v[i], 32'h0);
`ifdef BUS_SLAVE_CTRL_TIMEOUT_EN
          check("bus_err_idle", {31'b0, err_v[i]}, 32'h0);
`endif
        end
      end
    end
  end

  task automatic strobe(input int i, input logic r, input logic [29:0] a,
                        input logic [31:0] wd, input logic sel, output int k);
    @(posedge clk); #1;
    k = cyc;
    cs_n[i] = ~sel;
    as_n = 1'b0;
    rw = r;
    addr = a;
    wr_data = wd;
    @(posedge clk); #1;
    as_n = 1'b1;
    cs_n = 2'b11;
  endtask

  task automatic sb_push(input int i, input logic [31:0] d, input int due, input logic err);
    sb_t e;
    e.data = d;
    e.due = due;
    e.err = err;
    sb_q[i].push_back(e);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check("sb_drained", sb_q[i].size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, p;
    for (int i = 0; i < 2; i++) begin
      pulses[i] = 0; age[i] = 0; ack_delay[i] = 0; dev_rd[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_rdy", {31'b0, rdy_v[0]}, 32'h1);
    check("rst_req", {31'b0, dev_req_v[0]}, 32'h0);
    check("rst_addr", {2'b0, dev_addr_v[0]}, 32'h0);
    check("rst_rw", {31'b0, dev_rw_v[0]}, 32'h1);
    check("rst_wr", dev_wr_v[0], 32'h0);
    check("rst_rw3", {31'b0, dev_rw_v[1]}, 32'h1);

    // 1: zero wait states, read acked in the first request cycle
    ack_delay[0] = 0; dq[0].push_back(32'h12345678);
    strobe(0, 1'b1, 30'h10, 32'h0, 1'b1, k);
    sb_push(0, 32'h12345678, k + 2, 1'b0);
    @(negedge clk);
    check("t1_req", {31'b0, dev_req_v[0]}, 32'h1);
    check("t1_addr", {2'b0, dev_addr_v[0]}, 32'h10);
    check("t1_rw", {31'b0, dev_rw_v[0]}, 32'h1);
    drain(6);

    // 2: three wait states, write
    ack_delay[1] = 0; dq[1].push_back(32'hDEADBEEF);
    strobe(1, 1'b0, 30'h20, 32'hCAFEF00D, 1'b1, k);
    sb_push(1, 32'h0, k + 5, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t2_req_low", {31'b0, dev_req_v[1]}, 32'h0);
    end
    @(negedge clk);
    check("t2_req_high", {31'b0, dev_req_v[1]}, 32'h1);
    check("t2_wr", dev_wr_v[1], 32'hCAFEF00D);
    check("t2_rw", {31'b0, dev_rw_v[1]}, 32'h0);
    check("t2_addr", {2'b0, dev_addr_v[1]}, 32'h20);
    drain(8);

    // 3: deselected strobe, then a strobe during DEV
    p = pulses[0];
    strobe(0, 1'b1, 30'h30, 32'h0, 1'b0, k);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("t3_no_req", {31'b0, dev_req_v[0]}, 32'h0);
    end
    ack_delay[0] = 3; dq[0].push_back(32'hA5A50003);
    strobe(0, 1'b1, 30'h31, 32'h0, 1'b1, k);
    sb_push(0, 32'hA5A50003, k + 5, 1'b0);
    strobe(0, 1'b1, 30'h32, 32'h0, 1'b1, k2);
    @(negedge clk);
    check("t3_addr_kept", {2'b0, dev_addr_v[0]}, 32'h31);
    drain(8);
    check("t3_pulses", pulses[0], p + 1);

    // 4: back-to-back reads
    p = pulses[0];
    ack_delay[0] = 0; dq[0].push_back(32'h1); dq[0].push_back(32'h2);
    strobe(0, 1'b1, 30'h40, 32'h0, 1'b1, k);
    sb_push(0, 32'h1, k + 2, 1'b0);
    @(posedge clk);
    strobe(0, 1'b1, 30'h41, 32'h0, 1'b1, k);
    sb_push(0, 32'h2, k + 2, 1'b0);
    drain(6);
    check("t4_pulses", pulses[0], p + 2);

    // 5: reset mid-DEV, stray ack, then a normal access
    p = pulses[0];
    mute[0] = 1'b1;
    strobe(0, 1'b1, 30'h50, 32'h0, 1'b1, k);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("t5_req_async", {31'b0, dev_req_v[0]}, 32'h0);
    check("t5_rdy_async", {31'b0, rdy_v[0]}, 32'h1);
    check("t5_addr_async", {2'b0, dev_addr_v[0]}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    man_ack[0] = 1'b1;
    @(posedge clk); #1;
    man_ack[0] = 1'b0;
    @(negedge clk);
    check("t5_req_after_ack", {31'b0, dev_req_v[0]}, 32'h0);
    check("t5_no_rdy", pulses[0], p);
    mute[0] = 1'b0; dq[0].push_back(32'h5555AAAA);
    strobe(0, 1'b1, 30'h51, 32'h0, 1'b1, k);
    sb_push(0, 32'h5555AAAA, k + 2, 1'b0);
    drain(6);
    check("t5_pulses", pulses[0], p + 1);

`ifdef BUS_SLAVE_CTRL_TIMEOUT_EN
    // 6: timeout with no ack, then ack coinciding with expiry
    mute[0] = 1'b1;
    strobe(0, 1'b1, 30'h60, 32'h0, 1'b1, k);
    sb_push(0, 32'h0, k + 5, 1'b1);
    drain(8);
    mute[0] = 1'b0; ack_delay[0] = 3; dq[0].push_back(32'h600D);
    strobe(0, 1'b1, 30'h61, 32'h0, 1'b1, k);
    sb_push(0, 32'h600D, k + 5, 1'b0);
    drain(8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
